scheduling_delay_queue: RTL and testbench
=========================================

SCHEDULING_DELAY_QUEUE -- requirements
Module: scheduling_delay_queue

Interface
REQ-001 Parameter: WIDTH, 32, data width in bits (>=1).
REQ-002 Parameter: DELAY, 2, cycles from write to first live output cycle (>=1).
REQ-003 Parameter: LIVE, 1, cycles each value is held live on out (>=1).
REQ-004 Parameter: DEPTH, 4, maximum in-flight values (>=1; 1 is legal and degenerates to single-slot behaviour).
REQ-005 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-006 Port: reset  input  1  reset, asynchronous and active-low.
REQ-007 Port: write_en  input  1  write request; in is captured in the same cycle.
REQ-008 Port: in  input  WIDTH  data, valid in ['G, 'G+1] where G is the write cycle.
REQ-009 Port: out  output  WIDTH  data, valid in ['G+DELAY, 'G+DELAY+LIVE].
REQ-010 Port: out_valid  output  1  high exactly in cycles where out carries a live value.
REQ-011 Port: full  output  1  high when a write in this cycle would be rejected for lack of a slot.
REQ-012 Port: err  output  1  sticky protocol-violation flag.

Function
REQ-013 The block SHALL hold up to DEPTH overlapping in-flight values in FIFO order, each tracked by its own age counter of width clog2(DELAY+LIVE+1).
REQ-014 A write SHALL be accepted when write_en=1, err is not raised by this write (REQ-020/021), and occupancy<DEPTH or the head entry retires in the same cycle.
REQ-015 On acceptance in cycle G, the entry SHALL store in and start at age 0; age increments by one every cycle.
REQ-016 out and out_valid SHALL be registered; in cycle G+DELAY+k, 0<=k<LIVE, out = value written at G and out_valid = 1.
REQ-017 The head entry SHALL retire (occupancy decrements) at the end of cycle G+DELAY+LIVE-1.
REQ-018 When no entry is live, out SHALL hold the last live value and out_valid SHALL be 0.
REQ-019 Simultaneous accept and retire SHALL leave occupancy unchanged; full = (occupancy==DEPTH) and no retire this cycle.
REQ-020 A write in cycle G with a previously accepted write at G' where G-G'<LIVE SHALL be rejected (live windows would overlap) and set err.
REQ-021 A write rejected for lack of a slot SHALL set err; rejected writes SHALL not alter any entry, counter or output.
REQ-022 err SHALL remain 1 until reset; accepted traffic SHALL continue normally while err=1.
REQ-023 Writes at exactly LIVE-cycle spacing SHALL produce back-to-back live windows with out_valid continuously high.
REQ-024 Age counters and occupancy SHALL never wrap; an entry's age saturates semantics by retirement before reaching DELAY+LIVE.

Reset
REQ-025 reset low SHALL asynchronously clear all entries, occupancy, age counters and the write-spacing tracker.
REQ-026 During and after reset: out=0, out_valid=0, full=0, err=0.
REQ-027 Reset asserted mid-flight SHALL discard all pending values; no out_valid pulse from pre-reset writes after reset release.
REQ-028 write_en in the first cycle after reset deassertion SHALL be accepted normally.

Verification
REQ-029 DELAY=2, LIVE=1: write 0xA5 at cycle 10 -> out=0xA5, out_valid=1 only in cycle 12; out holds 0xA5 thereafter with out_valid=0.
REQ-030 DELAY=3, LIVE=1, DEPTH=4: writes 1,2,3 at cycles 5,6,7 -> out=1,2,3 in cycles 8,9,10, out_valid high 8-10, err=0.
REQ-031 DELAY=4, LIVE=1, DEPTH=2: writes at cycles 0,1,2 -> write at 2 rejected, full=1 in cycle 2, err=1; outputs for writes at 0 and 1 only, in cycles 4 and 5.
REQ-032 DELAY=2, LIVE=3: writes at 0 and 2 -> err=1, second rejected, out_valid high cycles 2-4 only; writes at 0 and 3 -> out_valid continuous 2-7, err=0.
REQ-033 DELAY=5: write 0x7 at cycle 0, reset low in cycle 2 for one cycle -> out=0, out_valid=0 through cycle 10, err=0.
REQ-034 DELAY=1, DEPTH=1, LIVE=1: writes every cycle 0-7 with data=cycle -> out=cycle-1 in cycles 1-8, full never 1, err=0.

Source files
------------

// File: rtl/scheduling_delay_queue.sv
`default_nettype none
// ============================================================================
// Module      : scheduling_delay_queue
// Description : FIFO of timed values, each presented on out for LIVE cycles
//               starting DELAY cycles after it was written.
// Revision    : 1.0 - initial release
// ============================================================================
module scheduling_delay_queue #(
    parameter int WIDTH = 32,
    parameter int DELAY = 2,
    parameter int LIVE  = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             full,
    output logic             err
);
    localparam int c_AGE_W = $clog2(DELAY + LIVE + 1);
    localparam int c_OCC_W = $clog2(DEPTH + 1);
    localparam int c_GAP_W = $clog2(LIVE + 1);
    // Stored age is 0 in the cycle after the write; an entry whose age lies
    // in [c_LIVE_FIRST, c_LIVE_LAST] drives out in the following cycle.
    localparam int c_LIVE_FIRST = DELAY - 2;
    localparam int c_LIVE_LAST  = DELAY + LIVE - 3;
    localparam int c_RETIRE     = DELAY + LIVE - 2;

    logic [WIDTH-1:0]   r_data [DEPTH];
    logic [c_AGE_W-1:0] r_age  [DEPTH];
    logic [c_OCC_W-1:0] r_occ;
    logic [c_GAP_W-1:0] r_gap;
    logic [WIDTH-1:0]   r_out;
    logic               r_out_valid;
    logic               r_err;

    logic [WIDTH-1:0]   w_data_nxt [DEPTH];
    logic [c_AGE_W-1:0] w_age_nxt  [DEPTH];
    logic [c_OCC_W-1:0] w_occ_kept;
    logic [c_OCC_W-1:0] w_occ_nxt;
    logic               w_retire;
    logic               w_too_close;
    logic               w_full;
    logic               w_accept;
    logic               w_reject;
    logic               w_load;
    logic [WIDTH-1:0]   w_load_data;

    always_comb begin
        w_retire    = (r_occ != '0) && (int'(r_age[0]) == c_RETIRE);
        w_too_close = (int'(r_gap) < LIVE);
        w_full      = (int'(r_occ) == DEPTH) && !w_retire;
        w_accept    = write_en && !w_too_close && !w_full;
        w_reject    = write_en && !w_accept;
        w_occ_kept  = w_retire ? r_occ - c_OCC_W'(1) : r_occ;

        // Spacing >= LIVE guarantees at most one entry is due at a time.
        w_load      = 1'b0;
        w_load_data = r_out;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(r_occ) && int'(r_age[i]) >= c_LIVE_FIRST &&
                int'(r_age[i]) <= c_LIVE_LAST) begin
                w_load      = 1'b1;
                w_load_data = r_data[i];
            end
        end
        if (DELAY == 1 && w_accept) begin
            w_load      = 1'b1;
            w_load_data = in;
        end

        for (int i = 0; i < DEPTH; i++) begin
            w_data_nxt[i] = r_data[i];
            w_age_nxt[i]  = (i < int'(r_occ)) ? r_age[i] + c_AGE_W'(1) : '0;
        end
        if (w_retire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_data_nxt[i] = r_data[i + 1];
                w_age_nxt[i]  = (i + 1 < int'(r_occ)) ? r_age[i + 1] + c_AGE_W'(1) : '0;
            end
            w_age_nxt[DEPTH - 1] = '0;
        end
        if (w_accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(w_occ_kept)) begin
                    w_data_nxt[i] = in;
                    w_age_nxt[i]  = '0;
                end
            end
        end
        w_occ_nxt = w_occ_kept + c_OCC_W'(w_accept);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_age[i]  <= '0;
            end
            r_occ       <= '0;
            r_gap       <= c_GAP_W'(LIVE);
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_data_nxt[i];
                r_age[i]  <= w_age_nxt[i];
            end
            r_occ       <= w_occ_nxt;
            r_out       <= w_load_data;
            r_out_valid <= w_load;
            r_err       <= r_err | w_reject;
            // Cycles since the last accepted write, saturating at LIVE.
            if (w_accept) begin
                r_gap <= c_GAP_W'(1);
            end else if (int'(r_gap) < LIVE) begin
                r_gap <= r_gap + c_GAP_W'(1);
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign full      = w_full;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_scheduling_delay_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_scheduling_delay_queue
// Description : Randomised bench for two queue configurations against a
//               write-log reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scheduling_delay_queue;
    localparam int c_W       = 8;
    localparam int c_A_DELAY = 4;
    localparam int c_A_LIVE  = 2;
    localparam int c_A_DEPTH = 2;
    localparam int c_B_DELAY = 1;
    localparam int c_B_LIVE  = 1;
    localparam int c_B_DEPTH = 1;

    typedef struct {
        int             g;
        logic [c_W-1:0] d;
    } wr_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           we_a, we_b;
    logic [c_W-1:0] din_a, din_b;
    logic [c_W-1:0] out_a, out_b;
    logic           valid_a, valid_b;
    logic           full_a, full_b;
    logic           err_a, err_b;

    wr_t log_q [2][$];
    bit  err_m [2];
    int  cyc;
    int  n_checks;
    int  n_errors;

    always #5 clk = ~clk;

    scheduling_delay_queue #(
        .WIDTH(c_W), .DELAY(c_A_DELAY), .LIVE(c_A_LIVE), .DEPTH(c_A_DEPTH)
    ) u_dut_a (
        .clk(clk), .reset(reset), .write_en(we_a), .in(din_a),
        .out(out_a), .out_valid(valid_a), .full(full_a), .err(err_a)
    );

    scheduling_delay_queue #(
        .WIDTH(c_W), .DELAY(c_B_DELAY), .LIVE(c_B_LIVE), .DEPTH(c_B_DEPTH)
    ) u_dut_b (
        .clk(clk), .reset(reset), .write_en(we_b), .in(din_b),
        .out(out_b), .out_valid(valid_b), .full(full_b), .err(err_b)
    );

    function automatic int p_delay(input int k);
        return (k == 0) ? c_A_DELAY : c_B_DELAY;
    endfunction
    function automatic int p_live(input int k);
        return (k == 0) ? c_A_LIVE : c_B_LIVE;
    endfunction
    function automatic int p_depth(input int k);
        return (k == 0) ? c_A_DEPTH : c_B_DEPTH;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input string stage, input logic [c_W-1:0] e_out,
                             input bit e_valid, input bit e_full, input bit e_err);
        logic [c_W-1:0] o;
        logic           v, f, e;
        string          pfx;
        if (k == 0) begin
            o = out_a; v = valid_a; f = full_a; e = err_a; pfx = "a.";
        end else begin
            o = out_b; v = valid_b; f = full_b; e = err_b; pfx = "b.";
        end
        check_value({pfx, stage, ".out"},       32'(o), 32'(e_out));
        check_value({pfx, stage, ".out_valid"}, 32'(v), 32'(e_valid));
        check_value({pfx, stage, ".full"},      32'(f), 32'(e_full));
        check_value({pfx, stage, ".err"},       32'(e), 32'(e_err));
    endtask

    task automatic drive(input int k, input logic w, input logic [c_W-1:0] d);
        if (k == 0) begin
            we_a = w; din_a = d;
        end else begin
            we_b = w; din_b = d;
        end
    endtask

    // Expected behaviour in the current cycle derived from the log of
    // accepted writes: live windows, residency and spacing.
    task automatic model_step(input int k, input logic w, output logic [c_W-1:0] e_out,
                              output bit e_valid, output bit e_full, output bit acc);
        int  d, l, occ, g;
        bit  retire, too_close;
        d = p_delay(k);
        l = p_live(k);
        occ = 0;
        retire = 1'b0;
        too_close = 1'b0;
        e_out = '0;
        e_valid = 1'b0;
        for (int i = 0; i < log_q[k].size(); i++) begin
            g = log_q[k][i].g;
            if (g + d <= cyc) e_out = log_q[k][i].d;
            if (g + d <= cyc && cyc < g + d + l) e_valid = 1'b1;
            if (g < cyc && cyc <= g + d + l - 1) occ++;
            if (g + d + l - 1 == cyc) retire = 1'b1;
            if (cyc - g < l) too_close = 1'b1;
        end
        e_full = (occ == p_depth(k)) && !retire;
        acc    = w && !too_close && !e_full;
    endtask

    task automatic run_cycle(input int pct_a, input int pct_b);
        for (int k = 0; k < 2; k++) begin
            logic           w;
            logic [c_W-1:0] d;
            logic [c_W-1:0] e_out;
            bit             e_valid, e_full, acc;
            wr_t            ent;
            w = ($urandom_range(0, 99) < ((k == 0) ? pct_a : pct_b));
            d = c_W'($urandom);
            model_step(k, w, e_out, e_valid, e_full, acc);
            check_dut(k, "run", e_out, e_valid, e_full, err_m[k]);
            if (acc) begin
                ent.g = cyc;
                ent.d = d;
                log_q[k].push_back(ent);
            end else if (w) begin
                err_m[k] = 1'b1;
            end
            drive(k, w, d);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic mid_reset();
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_dut(k, "rst", '0, 1'b0, 1'b0, 1'b0);
            log_q[k].delete();
            err_m[k] = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        reset = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_dut(k, "init", '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_cycle(100, 100);
        repeat (150) run_cycle(30, 50);
        repeat (150) run_cycle(90, 100);
        mid_reset();
        repeat (150) run_cycle(60, 70);
        repeat (3) run_cycle(100, 100);
        mid_reset();
        repeat (100) run_cycle(50, 50);
        repeat (60) run_cycle(0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
